// File: rtl/alu_pkg.sv
// Shared constants, field positions and FSM encoding for the ALU issue controller.
// Build macro ALU_ISSUE_MUL_EN makes opcode 2 (MUL) a legal instruction.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_CMP = 4'd6;

    localparam logic [2:0] SR_NONE = 3'b000;
    localparam logic [2:0] SR_RSH  = 3'b001;
    localparam logic [2:0] SR_LSH  = 3'b010;
    localparam logic [2:0] SR_ROR  = 3'b011;

    localparam int OPC_LO = 28;
    localparam int SRC_LO = 24;
    localparam int S_BIT  = 23;
    localparam int RD_LO  = 19;
    localparam int RN_LO  = 15;
    localparam int RM_LO  = 11;
    localparam int SRB_LO = 6;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_EXEC,
        ST_WB
    } state_e;

    function automatic logic op_legal(input logic [3:0] op);
`ifdef ALU_ISSUE_MUL_EN
        return (op <= OP_CMP);
`else
        return (op <= OP_CMP) && (op != OP_MUL);
`endif
    endfunction

endpackage

// File: rtl/alu_issue_flags.sv
// Next-state computation of the {N,Z,C,V} flags register.
module alu_issue_flags
    import alu_pkg::*;
(
    input  logic [31:0] in1_i,
    input  logic [31:0] in2_i,
    input  logic [31:0] result_i,
    input  logic [3:0]  opcode_i,
    input  logic [2:0]  sr_cont_i,
    input  logic        s_i,
    input  logic [3:0]  flags_i,
    output logic [3:0]  flags_o
);

    logic [32:0] sum;
    logic [32:0] diff;
    logic        is_cmp;
    logic        shifted;

    assign sum     = {1'b0, in1_i} + {1'b0, in2_i};
    assign diff    = {1'b0, in1_i} - {1'b0, in2_i};
    assign is_cmp  = (opcode_i == OP_CMP);
    assign shifted = (sr_cont_i == SR_RSH) || (sr_cont_i == SR_LSH) || (sr_cont_i == SR_ROR);

    always_comb begin
        flags_o = flags_i;
        if (s_i || is_cmp) begin
            flags_o[FLAG_N] = result_i[31];
            flags_o[FLAG_Z] = (result_i == 32'd0);
            // C/V describe the raw operand sum/difference, so a shifted operand leaves them alone
            if (!shifted) begin
                if (opcode_i == OP_ADD) begin
                    flags_o[FLAG_C] = sum[32];
                    flags_o[FLAG_V] = (in1_i[31] == in2_i[31]) && (sum[31] != in1_i[31]);
                end else if ((opcode_i == OP_SUB) || is_cmp) begin
                    flags_o[FLAG_C] = ~diff[32];
                    flags_o[FLAG_V] = (in1_i[31] != in2_i[31]) && (diff[31] != in1_i[31]);
                end
            end
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller around an external combinational ALU (IDLE->DECODE->EXEC->WB).
// Build macro ALU_ISSUE_MUL_EN enables MUL with MUL_LAT extra EXEC cycles.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int MUL_LAT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic [3:0]  alu_opcode,
    output logic [2:0]  alu_sr_cont,
    output logic [4:0]  alu_sr_bit,
    input  logic [31:0] alu_out,
    output logic [3:0]  flags,
    output logic        done,
    output logic        err,
    input  logic [3:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    localparam logic [1:0] MUL_CNT = 2'(MUL_LAT);

    state_e      state_q, state_d;
    logic [3:0]  opc_q, rd_q, rn_q, rm_q;
    logic [2:0]  src_q;
    logic        s_q;
    logic [4:0]  srb_q;
    logic [31:0] op1_q, op2_q, result_q;
    logic [3:0]  aop_q, flags_q, flags_d;
    logic [2:0]  asr_q;
    logic [4:0]  asb_q;
    logic [1:0]  cnt_q;
    logic        ill_q;
    logic [31:0] regs_q [16];

    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr[27], instr[5:0]};

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (instr_valid) state_d = ST_DECODE;
            ST_DECODE: state_d = op_legal(opc_q) ? ST_EXEC : ST_WB;
            ST_EXEC:   if (cnt_q == 2'd0) state_d = ST_WB;
            ST_WB:     state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            opc_q    <= '0;
            rd_q     <= '0;
            rn_q     <= '0;
            rm_q     <= '0;
            src_q    <= '0;
            s_q      <= 1'b0;
            srb_q    <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            aop_q    <= '0;
            asr_q    <= '0;
            asb_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            ill_q    <= 1'b0;
            flags_q  <= '0;
            for (int i = 0; i < 16; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: if (instr_valid) begin
                    opc_q <= instr[OPC_LO +: 4];
                    src_q <= instr[SRC_LO +: 3];
                    s_q   <= instr[S_BIT];
                    rd_q  <= instr[RD_LO +: 4];
                    rn_q  <= instr[RN_LO +: 4];
                    rm_q  <= instr[RM_LO +: 4];
                    srb_q <= instr[SRB_LO +: 5];
                end
                ST_DECODE: begin
                    ill_q <= !op_legal(opc_q);
                    cnt_q <= (opc_q == OP_MUL) ? MUL_CNT : 2'd0;
                    if (op_legal(opc_q)) begin
                        op1_q <= regs_q[rn_q];
                        op2_q <= regs_q[rm_q];
                        // CMP is a SUB whose result is only used for flags
                        aop_q <= (opc_q == OP_CMP) ? OP_SUB : opc_q;
                        asr_q <= src_q;
                        asb_q <= srb_q;
                    end
                end
                ST_EXEC: begin
                    if (cnt_q == 2'd0) result_q <= alu_out;
                    else               cnt_q    <= cnt_q - 2'd1;
                end
                ST_WB: if (!ill_q) begin
                    flags_q <= flags_d;
                    if (opc_q != OP_CMP) regs_q[rd_q] <= result_q;
                end
                default: ;
            endcase
        end
    end

    alu_issue_flags u_flags (
        .in1_i     (op1_q),
        .in2_i     (op2_q),
        .result_i  (result_q),
        .opcode_i  (opc_q),
        .sr_cont_i (asr_q),
        .s_i       (s_q),
        .flags_i   (flags_q),
        .flags_o   (flags_d)
    );

    assign instr_ready = (state_q == ST_IDLE) && !rst;
    assign done        = (state_q == ST_WB) && !ill_q;
    assign err         = (state_q == ST_WB) && ill_q;
    assign alu_in1     = op1_q;
    assign alu_in2     = op2_q;
    assign alu_opcode  = aop_q;
    assign alu_sr_cont = asr_q;
    assign alu_sr_bit  = asb_q;
    assign flags       = flags_q;
    assign dbg_data    = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural ALU and reference model.
module tb_alu_issue_ctrl;

    localparam int TB_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [31:0] alu_in1, alu_in2, alu_out;
    logic [3:0]  alu_opcode;
    logic [2:0]  alu_sr_cont;
    logic [4:0]  alu_sr_bit;
    logic [3:0]  flags;
    logic        done, err;
    logic [3:0]  dbg_addr;
    logic [31:0] dbg_data;

    int total = 0;
    int bad   = 0;

    logic [31:0] mregs [16];
    logic [3:0]  mflags;
    logic        ovr;
    logic [31:0] ovr_val;

    alu_issue_ctrl #(.MUL_LAT(TB_LAT)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_opcode(alu_opcode), .alu_sr_cont(alu_sr_cont), .alu_sr_bit(alu_sr_bit),
        .alu_out(alu_out), .flags(flags), .done(done), .err(err),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] shf(input logic [2:0] sc, input logic [4:0] n, input logic [31:0] v);
        logic [63:0] d;
        d = {v, v} >> n;
        case (sc)
            3'b001:  return v >> n;
            3'b010:  return v << n;
            3'b011:  return d[31:0];
            default: return v;
        endcase
    endfunction

    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a * b;
            4'd3:    return a | b;
            4'd4:    return a & b;
            4'd5:    return a ^ b;
            default: return 32'd0;
        endcase
    endfunction

    // External ALU; ovr lets the bench inject arbitrary values to preload registers
    always_comb begin
        alu_out = alu_f(alu_opcode, alu_in1, shf(alu_sr_cont, alu_sr_bit, alu_in2));
        if (ovr) alu_out = ovr_val;
    end

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [2:0] sc, input logic s,
                                       input logic [3:0] rd, input logic [3:0] rn, input logic [3:0] rm,
                                       input logic [4:0] sb);
        return {op, 1'b0, sc, s, rd, rn, rm, sb, 6'b0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic [31:0] ins, input logic oe, input logic [31:0] ov,
                              output logic legal, output int lat);
        logic [3:0]  op;
        logic [2:0]  sc;
        logic [31:0] a, b, res;
        longint      sres;
        bit          mul_en;
`ifdef ALU_ISSUE_MUL_EN
        mul_en = 1'b1;
`else
        mul_en = 1'b0;
`endif
        op    = ins[31:28];
        sc    = ins[26:24];
        legal = (op <= 4'd6) && ((op != 4'd2) || mul_en);
        lat   = 2;
        if (legal) begin
            lat = (op == 4'd2) ? 3 + TB_LAT : 3;
            a   = mregs[ins[18:15]];
            b   = mregs[ins[14:11]];
            res = oe ? ov : alu_f((op == 4'd6) ? 4'd1 : op, a, shf(sc, ins[10:6], b));
            if (ins[23] || op == 4'd6) begin
                mflags[3] = res[31];
                mflags[2] = (res == 32'd0);
                if ((op == 4'd0 || op == 4'd1 || op == 4'd6) && !(sc inside {3'd1, 3'd2, 3'd3})) begin
                    if (op == 4'd0) begin
                        mflags[1] = ({32'd0, a} + {32'd0, b}) > 64'hFFFF_FFFF;
                        sres = longint'($signed(a)) + longint'($signed(b));
                    end else begin
                        mflags[1] = (a >= b);
                        sres = longint'($signed(a)) - longint'($signed(b));
                    end
                    mflags[0] = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
                end
            end
            if (op != 4'd6) mregs[ins[22:19]] = res;
        end
    endtask

    task automatic issue(input logic [31:0] ins, input logic oe, input logic [31:0] ov);
        logic legal;
        int   lat;
        int   k;
        ovr     = oe;
        ovr_val = ov;
        k = 0;
        while (!instr_ready && k < 20) begin
            @(posedge clk); #1; k++;
        end
        instr       = ins;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        instr       = $urandom;
        model_step(ins, oe, ov, legal, lat);
        k = 1;
        while (!(done || err) && k < 12) begin
            @(posedge clk); #1; k++;
        end
        check("latency", k, lat);
        check("done", {31'd0, done}, {31'd0, legal});
        check("err", {31'd0, err}, {31'd0, !legal});
        @(posedge clk); #1;
        ovr = 1'b0;
        check("ready_after", {31'd0, instr_ready}, 32'd1);
        check("flags", {28'd0, flags}, {28'd0, mflags});
        dbg_addr = ins[22:19];
        #1;
        check("rd_value", dbg_data, mregs[ins[22:19]]);
    endtask

    task automatic load(input logic [3:0] r, input logic [31:0] v);
        issue(mk(4'd3, 3'd0, 1'b0, r, 4'd0, 4'd0, 5'd0), 1'b1, v);
    endtask

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 4'(i);
            #1;
            check(tag, dbg_data, mregs[i]);
        end
    endtask

    initial begin
        rst = 1'b1; instr_valid = 1'b0; instr = '0; dbg_addr = '0; ovr = 1'b0; ovr_val = '0;
        for (int i = 0; i < 16; i++) mregs[i] = '0;
        mflags = '0;
        @(posedge clk); @(posedge clk); #1;
        check("rst_ready", {31'd0, instr_ready}, 32'd0);
        check("rst_flags", {28'd0, flags}, 32'd0);
        check("rst_done_err", {30'd0, done, err}, 32'd0);
        check("rst_alu_in", alu_in1 | alu_in2, 32'd0);
        check("rst_alu_ctl", {20'd0, alu_opcode, alu_sr_cont, alu_sr_bit}, 32'd0);
        rst = 1'b0;
        #1;
        check("ready_out_of_rst", {31'd0, instr_ready}, 32'd1);
        check_all_regs("rst_regs");

        load(4'd1, 32'd5); load(4'd2, 32'd7);
        issue(mk(4'd0, 3'd0, 1'b1, 4'd3, 4'd1, 4'd2, 5'd0), 1'b0, 32'd0);
        check("add_r3", dbg_data, 32'd12);
        check("add_flags", {28'd0, flags}, 32'h0);

        load(4'd1, 32'h7FFF_FFFF); load(4'd2, 32'd1);
        issue(mk(4'd0, 3'd0, 1'b1, 4'd3, 4'd1, 4'd2, 5'd0), 1'b0, 32'd0);
        check("ovf_r3", dbg_data, 32'h8000_0000);
        check("ovf_flags", {28'd0, flags}, 32'b1001);

        load(4'd1, 32'd4); load(4'd2, 32'd4); load(4'd7, 32'hA5A5_0001);
        issue(mk(4'd6, 3'd0, 1'b0, 4'd7, 4'd1, 4'd2, 5'd0), 1'b0, 32'd0);
        check("cmp_no_write", dbg_data, 32'hA5A5_0001);
        check("cmp_flags", {28'd0, flags}, 32'b0110);

        load(4'd2, 32'd1);
        issue(mk(4'd0, 3'd2, 1'b1, 4'd4, 4'd0, 4'd2, 5'd4), 1'b0, 32'd0);
        check("lsl_r4", dbg_data, 32'h10);
        check("lsl_flags", {28'd0, flags}, 32'b0010);

        issue(mk(4'hF, 3'd0, 1'b1, 4'd4, 4'd1, 4'd2, 5'd0), 1'b0, 32'd0);
        check_all_regs("illegal_regs");
        issue(mk(4'd2, 3'd0, 1'b1, 4'd9, 4'd1, 4'd2, 5'd0), 1'b0, 32'd0);

        // Reset while an ADD r5 sits in EXEC
        load(4'd5, 32'h1234_5678);
        instr = mk(4'd0, 3'd0, 1'b1, 4'd5, 4'd1, 4'd2, 5'd0);
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("mid_rst_ready", {31'd0, instr_ready}, 32'd0);
        check("mid_rst_flags", {28'd0, flags}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) mregs[i] = '0;
        mflags = '0;
        #1;
        check("post_rst_ready", {31'd0, instr_ready}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("post_rst_no_done", {31'd0, done}, 32'd0);
            @(posedge clk); #1;
        end
        dbg_addr = 4'd5;
        #1;
        check("post_rst_r5", dbg_data, 32'd0);
        check("post_rst_flags", {28'd0, flags}, 32'd0);

        for (int i = 0; i < 16; i++) load(4'(i), $urandom);
        for (int n = 0; n < 40; n++) begin
            logic [3:0]  op;
            logic [31:0] ins;
            op  = 4'($urandom_range(0, 7));
            if (op == 4'd7) op = 4'hF;
            ins = mk(op, 3'($urandom_range(0, 7)), 1'($urandom), 4'($urandom), 4'($urandom),
                     4'($urandom), 5'($urandom));
            ins = ins | ({$urandom} & 32'h0800_003F);
            issue(ins, 1'b0, 32'd0);
        end
        check_all_regs("random_regs");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end

endmodule
